// File: rtl/tick_debouncer.sv
// Push-button debouncer: a two-flop synchronizer followed by a four-state
// qualification FSM. A new level is accepted only after it has held for
// STABLE_TICKS consecutive sample_tick strobes. The block produces a clean
// level plus single-cycle press and release pulses.
module tick_debouncer #(
  parameter int unsigned STABLE_TICKS     = 4,
  parameter bit          ACTIVE_LOW_INPUT = 1'b1,
  parameter int unsigned NBITS_FOR_STABLE = $clog2(STABLE_TICKS + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic button_in,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    PRESS_CHECK   = 2'd1,
    HELD          = 2'd2,
    RELEASE_CHECK = 2'd3
  } state_t;

  // Raw pin level that normalizes to "released"
  localparam logic PIN_RELEASED = ACTIVE_LOW_INPUT;
  // Counter value at which the qualifying tick is seen
  localparam logic [NBITS_FOR_STABLE-1:0] CNT_LAST =
    NBITS_FOR_STABLE'(STABLE_TICKS - 1);

  logic                        ff1;
  logic                        ff2;
  logic                        sync;
  state_t                      state;
  logic [NBITS_FOR_STABLE-1:0] cnt;

  // Two-flop synchronizer; resets to the released pin level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff1 <= PIN_RELEASED;
      ff2 <= PIN_RELEASED;
    end else begin
      ff1 <= button_in;
      ff2 <= ff1;
    end
  end

  // 1 = pressed, regardless of pin polarity
  assign sync = ff2 ^ ACTIVE_LOW_INPUT;

  // Qualification FSM. The outputs are registered together with the state, so
  // each branch sets them to the decode of the state it moves to. A level
  // reversal is tested before the tick, so a bounce beats a coincident final
  // tick. A tick in the entry cycle is ignored because entry happens from a
  // non-CHECK state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      debounced     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      busy          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= PRESS_CHECK;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS_CHECK: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (sample_tick) begin
            if (cnt == CNT_LAST) begin
              state       <= HELD;
              cnt         <= '0;
              busy        <= 1'b0;
              debounced   <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (!sync) begin
            state <= RELEASE_CHECK;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RELEASE_CHECK: begin
          if (sync) begin
            state <= HELD;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (sample_tick) begin
            if (cnt == CNT_LAST) begin
              state         <= IDLE;
              cnt           <= '0;
              busy          <= 1'b0;
              debounced     <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          busy      <= 1'b0;
          debounced <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_debouncer.sv
// Directed bench for tick_debouncer. The main instance uses STABLE_TICKS=4 and
// a sample_tick on every 10th clk. A second instance uses STABLE_TICKS=1 with
// sample_tick tied high.
module tb_tick_debouncer;

  logic clk;
  logic reset;
  logic sample_tick;
  logic button_in;
  logic debounced, press_pulse, release_pulse, busy;
  logic b1;
  logic debounced1, press1, release1, busy1;

  int errors = 0;
  int checks = 0;
  int press_seen = 0;
  int release_seen = 0;
  int deb0_seen = 0;

  tick_debouncer #(.STABLE_TICKS(4), .ACTIVE_LOW_INPUT(1'b1)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .button_in(button_in),
    .debounced(debounced), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .busy(busy)
  );

  tick_debouncer #(.STABLE_TICKS(1), .ACTIVE_LOW_INPUT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(1'b1), .button_in(b1),
    .debounced(debounced1), .press_pulse(press1),
    .release_pulse(release1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: drive the tick, take the edge, sample 1 time unit later
  task automatic clk1(input logic t);
    sample_tick = t;
    @(posedge clk);
    #1;
    press_seen   += int'(press_pulse);
    release_seen += int'(release_pulse);
    deb0_seen    += int'(!debounced);
  endtask

  task automatic idle(input int n);
    repeat (n) clk1(1'b0);
  endtask

  // n tick periods of 10 clk, each with its tick in the last cycle
  task automatic ticks(input int n);
    repeat (n) begin
      idle(9);
      clk1(1'b1);
    end
  endtask

  initial begin
    reset = 1'b0; sample_tick = 1'b0; button_in = 1'b1; b1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_debounced", int'(debounced), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    idle(2);

    // 1: clean press; the tick in the entry cycle must not count
    press_seen = 0;
    button_in = 1'b0;
    idle(2);
    check("t1_busy_pre", int'(busy), 0);
    clk1(1'b1);
    check("t1_busy_entry", int'(busy), 1);
    check("t1_deb_entry", int'(debounced), 0);
    ticks(3);
    idle(9);
    check("t1_no_early_press", press_seen, 0);
    check("t1_busy_qual", int'(busy), 1);
    clk1(1'b1);
    check("t1_press", int'(press_pulse), 1);
    check("t1_deb", int'(debounced), 1);
    check("t1_busy_done", int'(busy), 0);
    clk1(1'b0);
    check("t1_press_1cyc", int'(press_pulse), 0);
    ticks(2);
    check("t1_press_count", press_seen, 1);
    check("t1_deb_hold", int'(debounced), 1);

    // 3: release glitch of 15 clk while HELD
    release_seen = 0; deb0_seen = 0;
    button_in = 1'b1;
    idle(3);
    check("t3_busy_glitch", int'(busy), 1);
    idle(6);
    clk1(1'b1);
    idle(5);
    button_in = 1'b0;
    idle(2);
    check("t3_busy_still", int'(busy), 1);
    clk1(1'b0);
    check("t3_busy_back", int'(busy), 0);
    check("t3_deb_back", int'(debounced), 1);
    check("t3_deb_never_low", deb0_seen, 0);
    check("t3_no_release", release_seen, 0);
    // full release
    button_in = 1'b1;
    idle(3);
    check("t3_busy_rel", int'(busy), 1);
    ticks(3);
    idle(9);
    check("t3_no_early_rel", release_seen, 0);
    clk1(1'b1);
    check("t3_release", int'(release_pulse), 1);
    check("t3_deb_rel", int'(debounced), 0);
    check("t3_busy_rel_done", int'(busy), 0);
    clk1(1'b0);
    check("t3_release_1cyc", int'(release_pulse), 0);
    check("t3_release_count", release_seen, 1);

    // 2: bouncy press, pin toggles every 3 clk for 30 clk, then held low
    press_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      button_in = (((k - 1) / 3) % 2 == 1);
      clk1(k % 10 == 0);
    end
    check("t2_no_press_bounce", press_seen, 0);
    check("t2_deb_bounce", int'(debounced), 0);
    check("t2_idle_after_bounce", int'(busy), 0);
    button_in = 1'b0;
    idle(3);
    check("t2_busy", int'(busy), 1);
    ticks(3);
    idle(9);
    clk1(1'b1);
    check("t2_press", int'(press_pulse), 1);
    check("t2_press_count", press_seen, 1);

    // 4: bounce coincident with the final tick
    button_in = 1'b1;
    idle(3);
    ticks(4);
    check("t4_released", int'(debounced), 0);
    press_seen = 0;
    button_in = 1'b0;
    idle(3);
    check("t4_busy", int'(busy), 1);
    ticks(3);
    idle(7);
    button_in = 1'b1;
    idle(2);
    check("t4_busy_pre", int'(busy), 1);
    clk1(1'b1);
    check("t4_busy_revert", int'(busy), 0);
    check("t4_deb", int'(debounced), 0);
    check("t4_no_press", int'(press_pulse), 0);
    clk1(1'b0);
    check("t4_press_count", press_seen, 0);

    // 5: reset after two ticks of qualification
    button_in = 1'b0;
    idle(3);
    ticks(2);
    idle(3);
    check("t5_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_deb", int'(debounced), 0);
    check("t5_rst_press", int'(press_pulse), 0);
    check("t5_rst_release", int'(release_pulse), 0);
    idle(2);
    reset = 1'b1;
    press_seen = 0;
    idle(2);
    check("t5_busy_resync", int'(busy), 0);
    clk1(1'b0);
    check("t5_busy_requal", int'(busy), 1);
    ticks(3);
    idle(9);
    check("t5_no_early_press", press_seen, 0);
    clk1(1'b1);
    check("t5_press", int'(press_pulse), 1);

    // 6: STABLE_TICKS=1 with sample_tick tied high: pulse after the 4th edge
    b1 = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      clk1(1'b0);
      check($sformatf("t6_no_press_edge%0d", e), int'(press1), 0);
    end
    clk1(1'b0);
    check("t6_press", int'(press1), 1);
    check("t6_deb", int'(debounced1), 1);
    clk1(1'b0);
    check("t6_press_1cyc", int'(press1), 0);
    check("t6_busy", int'(busy1), 0);
    check("t6_no_release", int'(release1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
